serial_add_sub: RTL and testbench
=================================

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, meaning bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT and DIGIT >= 1.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  operand set presented.
REQ-006 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-007 The block SHALL have port a  input  WIDTH  first operand.
REQ-008 The block SHALL have port b  input  WIDTH  second operand.
REQ-009 The block SHALL have port cin  input  1  carry-in.
REQ-010 The block SHALL have port sign  input  1  1 = invert b before adding (subtract mode).
REQ-011 The block SHALL have port out_valid  output  1  result available.
REQ-012 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-013 The block SHALL have port sum  output  WIDTH  result.
REQ-014 The block SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-015 The block SHALL have port ovf  output  1  two's-complement overflow.
REQ-016 The block SHALL have port zero  output  1  sum == 0.

Function
REQ-017 The result SHALL be {cout,sum} = a + (sign ? ~b : b) + cin; subtraction a-b requires sign=1, cin=1 from the caller (cin is never forced internally).
REQ-018 The FSM SHALL have states IDLE, RUN, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-019 Accept SHALL occur on a clk edge with in_valid=1 in IDLE: a, b^{WIDTH{sign}}, cin are latched; the FSM enters RUN with digit counter = 0; later input changes are ignored.
REQ-020 Each RUN cycle SHALL add one DIGIT-bit slice, LSB slice first, using the carry register; the slice result is written into the matching slice of the result register and the carry register is updated.
REQ-021 On the cycle processing the last slice (counter = WIDTH/DIGIT-1), the FSM SHALL enter DONE.
REQ-022 Latency SHALL be exactly WIDTH/DIGIT cycles: out_valid rises on the WIDTH/DIGIT-th edge after the accept edge.
REQ-023 ovf SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-024 zero SHALL be 1 iff all WIDTH result bits are 0, independent of cout.
REQ-025 sum, cout, ovf, zero SHALL be registered; they SHALL be stable throughout DONE and SHALL keep the last completed result after leaving DONE until the next result completes.
REQ-026 In DONE with out_ready=1 the FSM SHALL return to IDLE on that edge; with out_ready=0 it SHALL stay in DONE indefinitely (backpressure).
REQ-027 in_valid during RUN or DONE SHALL be ignored; no operand set is accepted on the same edge that leaves DONE.
REQ-028 The RUN phase SHALL contain no combinational carry chain longer than DIGIT bits.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force IDLE, counter 0, carry 0, sum 0, cout 0, ovf 0, zero 0, out_valid 0, in_ready 1.
REQ-030 Reset asserted in RUN or DONE SHALL discard the operation in progress; no out_valid is produced for it.
REQ-031 After rst deasserts, the first clk edge with in_valid=1 SHALL be a valid accept.

Verification
REQ-032 WIDTH=16, DIGIT=4: a=0x7FFF, b=0x0001, cin=0, sign=0 -> out_valid 4 cycles after accept, sum=0x8000, cout=0, ovf=1, zero=0.
REQ-033 a=0x1234, b=0x1234, sign=1, cin=1 -> sum=0x0000, cout=1, ovf=0, zero=1.
REQ-034 a=0xFFFF, b=0x0001, sign=0, cin=0 -> sum=0x0000, cout=1, ovf=0, zero=1; a=0x8000, b=0x0001, sign=1, cin=1 -> sum=0x7FFF, ovf=1.
REQ-035 Hold out_ready=0 for 3 cycles in DONE while toggling a, b and in_valid -> out_valid and all result outputs unchanged, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-036 Assert rst mid-RUN (after 2 slices) -> all outputs 0, in_ready=1 immediately; next accept of 0x0003+0x0004 gives 0x0007 after 4 cycles.
REQ-037 WIDTH=8, DIGIT=1: a=0x80, b=0x80, sign=0, cin=0 -> latency 8 cycles, sum=0x00, cout=1, ovf=1, zero=1.

Source files
------------

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - digit-serial adder/subtractor with valid/ready handshake
// Adds one DIGIT-bit slice per cycle through a carry register; results held until the next completes.
module serial_add_sub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSLICE = WIDTH / DIGIT;
   localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   int               base;
   logic [DIGIT-1:0] slice_a, slice_b, slice_s;
   logic             slice_c, msb_cin;

   // Only a DIGIT-bit ripple exists between the carry register and the next carry.
   always_comb begin
      base    = int'(cnt_q) * DIGIT;
      slice_a = op_a_q[base +: DIGIT];
      slice_b = op_b_q[base +: DIGIT];
      {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{DIGIT{1'b0}}, carry_q};
      msb_cin = slice_a[DIGIT-1] ^ slice_b[DIGIT-1] ^ slice_s[DIGIT-1];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      res_d       = res_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_a_d     = a;
               op_b_d     = b ^ {WIDTH{sign}};
               carry_d    = cin;
               cnt_d      = '0;
               state_d    = RUN;
               in_ready_d = 1'b0;
            end
         end
         RUN: begin
            res_d[base +: DIGIT] = slice_s;
            carry_d = slice_c;
            if (cnt_q == LAST) begin
               cnt_d       = '0;
               state_d     = DONE;
               out_valid_d = 1'b1;
               sum_d       = res_d;
               cout_d      = slice_c;
               ovf_d       = msb_cin ^ slice_c;
               zero_d      = (res_d == '0);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         res_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         res_q       <= res_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - scoreboard bench for serial_add_sub (16/4 and 8/1 instances)
module tb_serial_add_sub;

   localparam int LAT16 = 4;
   localparam int LAT8  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, cin, sign, out_valid, out_ready, cout, ovf, zero;
   logic [15:0] a, b, sum;
   logic        in_valid_8, in_ready_8, cin_8, sign_8, out_valid_8, out_ready_8, cout_8, ovf_8, zero_8;
   logic [7:0]  a_8, b_8, sum_8;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [15:0] sum;
      logic        cout, ovf, zero;
   } exp_t;
   typedef struct {
      logic [7:0] sum;
      logic       cout, ovf, zero;
   } exp8_t;

   exp_t  sb[$];
   exp8_t sb8[$];

   serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sign(sign),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
      .a(a_8), .b(b_8), .cin(cin_8), .sign(sign_8),
      .out_valid(out_valid_8), .out_ready(out_ready_8),
      .sum(sum_8), .cout(cout_8), .ovf(ovf_8), .zero(zero_8)
   );

   function automatic exp_t model16(logic [15:0] x, logic [15:0] y, logic ci, logic s);
      exp_t        e;
      logic [15:0] yy;
      logic [16:0] f;
      yy = s ? ~y : y;
      f = {1'b0, x} + {1'b0, yy} + {16'd0, ci};
      e.sum  = f[15:0];
      e.cout = f[16];
      e.ovf  = (x[15] == yy[15]) && (f[15] != x[15]);
      e.zero = (f[15:0] == 16'd0);
      return e;
   endfunction

   task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s,
                         input exp_t e);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      a = x; b = y; cin = ci; sign = s; in_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out16(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic s,
                        input exp8_t e);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (in_ready_8) break;
      end
      a_8 = x; b_8 = y; cin_8 = ci; sign_8 = s; in_valid_8 = 1'b1;
      sb8.push_back(e);
      @(posedge clk);
      #1 in_valid_8 = 1'b0;
   endtask

   task automatic wait_out8(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (out_valid_8) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic release16();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      nvec++;
      if ({in_ready, out_valid, sum, cout, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
         nerr++;
         $display("FAIL reset16 got rdy=%b vld=%b sum=%h c=%b o=%b z=%b want rdy=1 vld=0 sum=0000 c/o/z=0",
                  in_ready, out_valid, sum, cout, ovf, zero);
      end
      nvec++;
      if ({in_ready_8, out_valid_8, sum_8, cout_8, ovf_8, zero_8} !== {1'b1, 1'b0, 8'h0, 3'b000}) begin
         nerr++;
         $display("FAIL reset8 got rdy=%b vld=%b sum=%h c=%b o=%b z=%b want rdy=1 vld=0 sum=00 c/o/z=0",
                  in_ready_8, out_valid_8, sum_8, cout_8, ovf_8, zero_8);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_spec_vectors();
      logic [15:0] va[4] = '{16'h7FFF, 16'h1234, 16'hFFFF, 16'h8000};
      logic [15:0] vb[4] = '{16'h0001, 16'h1234, 16'h0001, 16'h0001};
      logic        vs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic        vc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_t        ve[4];
      exp_t        e;
      int          lat;
      ve[0] = '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
      ve[1] = '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1};
      ve[2] = '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1};
      ve[3] = '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0};
      for (int i = 0; i < 4; i++) begin
         send16(va[i], vb[i], vc[i], vs[i], ve[i]);
         wait_out16(lat);
         e = sb.pop_front();
         nvec++;
         if (lat !== LAT16) begin
            nerr++;
            $display("FAIL spec_latency[%0d] got %0d want %0d", i, lat, LAT16);
         end
         nvec++;
         if ({sum, cout, ovf, zero} !== {e.sum, e.cout, e.ovf, e.zero}) begin
            nerr++;
            $display("FAIL spec_result[%0d] got sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                     i, sum, cout, ovf, zero, e.sum, e.cout, e.ovf, e.zero);
         end
         release16();
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   lat;
      send16(16'h1357, 16'h2468, 1'b0, 1'b0, model16(16'h1357, 16'h2468, 1'b0, 1'b0));
      wait_out16(lat);
      e = sb.pop_front();
      nvec++;
      if ({sum, cout, ovf, zero} !== {e.sum, e.cout, e.ovf, e.zero}) begin
         nerr++;
         $display("FAIL bp_result got sum=%h want %h", sum, e.sum);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 16'($urandom); b = 16'($urandom); in_valid = ~in_valid;
         @(posedge clk);
         #1;
         nvec++;
         if ({out_valid, in_ready, sum, cout, ovf, zero} !== {1'b1, 1'b0, e.sum, e.cout, e.ovf, e.zero}) begin
            nerr++;
            $display("FAIL bp_hold[%0d] got vld=%b rdy=%b sum=%h c=%b o=%b z=%b want vld=1 rdy=0 sum=%h",
                     i, out_valid, in_ready, sum, cout, ovf, zero, e.sum);
         end
      end
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b0;
      nvec++;
      if ({out_valid, in_ready, sum, cout, ovf, zero} !== {1'b0, 1'b1, e.sum, e.cout, e.ovf, e.zero}) begin
         nerr++;
         $display("FAIL bp_release got vld=%b rdy=%b sum=%h want vld=0 rdy=1 sum=%h",
                  out_valid, in_ready, sum, e.sum);
      end
      @(posedge clk);
      #1;
      nvec++;
      if (in_ready !== 1'b1) begin
         nerr++;
         $display("FAIL bp_no_accept_on_leave got rdy=%b want 1", in_ready);
      end
   endtask

   task automatic test_mid_run_reset();
      exp_t e;
      int   lat;
      bit   seen;
      send16(16'h1111, 16'h2222, 1'b0, 1'b0, model16(16'h1111, 16'h2222, 1'b0, 1'b0));
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      void'(sb.pop_back());
      nvec++;
      if ({in_ready, out_valid, sum, cout, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
         nerr++;
         $display("FAIL midrun_reset got rdy=%b vld=%b sum=%h c=%b o=%b z=%b want rdy=1 vld=0 sum=0000 c/o/z=0",
                  in_ready, out_valid, sum, cout, ovf, zero);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      nvec++;
      if (seen !== 1'b0) begin
         nerr++;
         $display("FAIL midrun_discard got out_valid=1 want none");
      end
      send16(16'h0003, 16'h0004, 1'b0, 1'b0, '{sum: 16'h0007, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
      wait_out16(lat);
      e = sb.pop_front();
      nvec++;
      if (lat !== LAT16 || sum !== e.sum || {cout, ovf, zero} !== {e.cout, e.ovf, e.zero}) begin
         nerr++;
         $display("FAIL post_reset_add got lat=%0d sum=%h c/o/z=%b%b%b want lat=%0d sum=%h c/o/z=000",
                  lat, sum, cout, ovf, zero, LAT16, e.sum);
      end
      release16();
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      int          lat;
      logic [15:0] x, y;
      logic        ci, s;
      out_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         x = 16'($urandom); y = 16'($urandom);
         ci = 1'($urandom); s = 1'($urandom);
         if (i == 0) begin x = 16'h0000; y = 16'hFFFF; s = 1'b1; ci = 1'b1; end
         send16(x, y, ci, s, model16(x, y, ci, s));
         wait_out16(lat);
         e = sb.pop_front();
         nvec++;
         if (lat !== LAT16 || {sum, cout, ovf, zero} !== {e.sum, e.cout, e.ovf, e.zero}) begin
            nerr++;
            $display("FAIL b2b[%0d] %h %s %h ci=%b got lat=%0d sum=%h c=%b o=%b z=%b want lat=%0d sum=%h c=%b o=%b z=%b",
                     i, x, s ? "-" : "+", y, ci, lat, sum, cout, ovf, zero, LAT16, e.sum, e.cout, e.ovf, e.zero);
         end
      end
      out_ready = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_width8();
      logic [7:0] va[3] = '{8'h80, 8'h7F, 8'h05};
      logic [7:0] vb[3] = '{8'h80, 8'h01, 8'h03};
      logic       vs[3] = '{1'b0, 1'b0, 1'b1};
      logic       vc[3] = '{1'b0, 1'b0, 1'b1};
      exp8_t      ve[3];
      exp8_t      e;
      int         lat;
      ve[0] = '{sum: 8'h00, cout: 1'b1, ovf: 1'b1, zero: 1'b1};
      ve[1] = '{sum: 8'h80, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
      ve[2] = '{sum: 8'h02, cout: 1'b1, ovf: 1'b0, zero: 1'b0};
      for (int i = 0; i < 3; i++) begin
         send8(va[i], vb[i], vc[i], vs[i], ve[i]);
         wait_out8(lat);
         e = sb8.pop_front();
         nvec++;
         if (lat !== LAT8) begin
            nerr++;
            $display("FAIL w8_latency[%0d] got %0d want %0d", i, lat, LAT8);
         end
         nvec++;
         if ({sum_8, cout_8, ovf_8, zero_8} !== {e.sum, e.cout, e.ovf, e.zero}) begin
            nerr++;
            $display("FAIL w8_result[%0d] got sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                     i, sum_8, cout_8, ovf_8, zero_8, e.sum, e.cout, e.ovf, e.zero);
         end
         out_ready_8 = 1'b1;
         @(posedge clk);
         #1 out_ready_8 = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sign = 1'b0; out_ready = 1'b0;
      in_valid_8 = 1'b0; a_8 = '0; b_8 = '0; cin_8 = 1'b0; sign_8 = 1'b0; out_ready_8 = 1'b0;
      test_reset();
      test_spec_vectors();
      test_backpressure();
      test_mid_run_reset();
      test_back_to_back();
      test_width8();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
